seg7_scan_ctrl: RTL and testbench

Time-multiplexed display controller that shares one `seg7_decoder` (common-anode, active-low segments) across `NUM_DIGITS` digit positions. It drives the anode enables in a fixed round-robin scan and inserts a blanking guard interval between digits to suppress ghosting. New BCD words arrive through a valid/ready handshake and are committed only at frame boundaries, so a frame never shows a mix of old and new digits. Optional leading-zero blanking is supported. The block sits between the application counters/datapath and the board's seven-segment pins.

---
 rtl/seg7_pkg.sv | 13 +
 rtl/seg7_decoder.sv | 26 ++
 rtl/seg7_scan_ctrl.sv | 150 +++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seg7_pkg;

    typedef enum logic {
        GUARD = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seg7_decoder.sv
// BCD to common-anode seven-segment decoder, {g,f,e,d,c,b,a} active low.
module seg7_decoder
    import seg7_pkg::*;
(
    input  bcd_digit_t digit,
    output logic [6:0] seg_n
);

    // Standard digit patterns; codes above 9 blank silently
    always_comb begin
        case (digit)
            4'd0:    seg_n = 7'b1000000;
            4'd1:    seg_n = 7'b1111001;
            4'd2:    seg_n = 7'b0100100;
            4'd3:    seg_n = 7'b0110000;
            4'd4:    seg_n = 7'b0011001;
            4'd5:    seg_n = 7'b0010010;
            4'd6:    seg_n = 7'b0000010;
            4'd7:    seg_n = 7'b1111000;
            4'd8:    seg_n = 7'b0000000;
            4'd9:    seg_n = 7'b0010000;
            default: seg_n = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment scanner with guard blanking, frame-aligned word
// commit through a one-deep pending buffer, and optional leading-zero blanking.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DIGIT_CYCLES = 50000,
    parameter int GUARD_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_bcd,
    input  logic                    blank_lz,
    output logic [6:0]              seg_n,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    frame_done
);

    localparam int CW = $clog2(DIGIT_CYCLES);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int DW = 4 * NUM_DIGITS;

    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_PRE    = CW'(DIGIT_CYCLES - 2);
    localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYCLES - 1);
    localparam logic [IW-1:0] IDX_ONE    = IW'(1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    scan_state_t           state_r;
    logic [CW-1:0]         cnt_r;
    logic [IW-1:0]         idx_r;
    logic [DW-1:0]         active_r;
    logic [DW-1:0]         pend_buf_r;
    logic                  pending_r;
    logic [NUM_DIGITS-1:0] mask_r;
    logic [6:0]            seg_n_r;
    logic [NUM_DIGITS-1:0] an_n_r;
    logic                  frame_done_r;

    logic                  commit_s;
    logic                  xfer_s;
    logic [DW-1:0]         commit_word_s;
    bcd_digit_t            digit_s;
    logic [6:0]            dec_seg_s;
    logic [6:0]            seg_next_s;
    logic [NUM_DIGITS-1:0] an_next_s;

    // Digit i is masked when it and every more significant nibble are zero
    function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [DW-1:0] word,
                                                      input logic          en);
        logic zero_above;
        zero_above = 1'b1;
        lz_mask    = {NUM_DIGITS{1'b0}};
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above & (word[i*4 +: 4] == 4'd0);
            lz_mask[i] = en & zero_above & (i != 0);
        end
    endfunction

    assign commit_s   = (idx_r == IDX_LAST) && (cnt_r == CNT_LAST);
    assign xfer_s     = load_valid && !pending_r;
    assign load_ready = !pending_r;
    assign seg_n      = seg_n_r;
    assign an_n       = an_n_r;
    assign frame_done = frame_done_r;

    // Word that becomes active at commit: pending first, else a same-cycle bypass
    always_comb begin
        commit_word_s = active_r;
        if (pending_r) begin
            commit_word_s = pend_buf_r;
        end else if (load_valid) begin
            commit_word_s = load_bcd;
        end else begin
            commit_word_s = active_r;
        end
    end

    // Slot counter, digit index and guard/show sequencing
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= GUARD;
            cnt_r   <= {CW{1'b0}};
            idx_r   <= {IW{1'b0}};
        end else if (cnt_r == CNT_LAST) begin
            state_r <= GUARD;
            cnt_r   <= {CW{1'b0}};
            idx_r   <= (idx_r == IDX_LAST) ? {IW{1'b0}} : idx_r + IDX_ONE;
        end else begin
            cnt_r <= cnt_r + CNT_ONE;
            if (state_r == GUARD && cnt_r == GUARD_LAST) begin
                state_r <= SHOW;
            end
        end
    end

    // Handshake capture and frame-boundary commit of the display word
    always_ff @(posedge clk) begin
        if (rst) begin
            active_r   <= {DW{1'b0}};
            pend_buf_r <= {DW{1'b0}};
            pending_r  <= 1'b0;
            mask_r     <= {NUM_DIGITS{1'b0}};
        end else if (commit_s) begin
            active_r  <= commit_word_s;
            mask_r    <= lz_mask(commit_word_s, blank_lz);
            pending_r <= 1'b0;
        end else if (xfer_s) begin
            pend_buf_r <= load_bcd;
            pending_r  <= 1'b1;
        end
    end

    assign digit_s = active_r[{idx_r, 2'b00} +: 4];

    seg7_decoder u_dec (
        .digit (digit_s),
        .seg_n (dec_seg_s)
    );

    // Guard and mask blanking applied after the decoder
    always_comb begin
        an_next_s  = {NUM_DIGITS{1'b1}};
        seg_next_s = SEG_BLANK;
        if (state_r == SHOW) begin
            an_next_s[idx_r] = 1'b0;
            seg_next_s       = mask_r[idx_r] ? SEG_BLANK : dec_seg_s;
        end else begin
            an_next_s  = {NUM_DIGITS{1'b1}};
            seg_next_s = SEG_BLANK;
        end
    end

    // Output registers; frame_done is pre-decoded so it is high on the commit cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_n_r      <= SEG_BLANK;
            an_n_r       <= {NUM_DIGITS{1'b1}};
            frame_done_r <= 1'b0;
        end else begin
            seg_n_r      <= seg_next_s;
            an_n_r       <= an_next_s;
            frame_done_r <= (idx_r == IDX_LAST) && (cnt_r == CNT_PRE);
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench: per-cycle reference model of the scan plus directed literal checks.
module tb_seg7_scan_ctrl;

    localparam int N     = 4;
    localparam int DC    = 8;
    localparam int GC    = 2;
    localparam int FRAME = N * DC;

    logic        clk;
    logic        rst;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_bcd;
    logic        blank_lz;
    logic [6:0]  seg_n;
    logic [3:0]  an_n;
    logic        frame_done;

    seg7_scan_ctrl #(
        .NUM_DIGITS   (N),
        .DIGIT_CYCLES (DC),
        .GUARD_CYCLES (GC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_bcd   (load_bcd),
        .blank_lz   (blank_lz),
        .seg_n      (seg_n),
        .an_n       (an_n),
        .frame_done (frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    logic [6:0]  dec_tab [16];
    int          phase;
    int          m_slot;
    int          m_off;
    logic [15:0] m_act;
    logic [15:0] m_pend_word;
    logic [15:0] m_w;
    bit          m_pend;
    logic [3:0]  m_mask;
    logic [6:0]  m_seg;
    logic [3:0]  m_an;
    bit          started = 1'b0;

    initial begin
        dec_tab[0] = 7'b1000000; dec_tab[1] = 7'b1111001;
        dec_tab[2] = 7'b0100100; dec_tab[3] = 7'b0110000;
        dec_tab[4] = 7'b0011001; dec_tab[5] = 7'b0010010;
        dec_tab[6] = 7'b0000010; dec_tab[7] = 7'b1111000;
        dec_tab[8] = 7'b0000000; dec_tab[9] = 7'b0010000;
        for (int k = 10; k < 16; k++) dec_tab[k] = 7'h7F;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Highest non-zero digit stays lit; everything above it is blanked
    function automatic logic [3:0] lz_model(input logic [15:0] w, input logic en);
        int h;
        h = 0;
        for (int j = 0; j < N; j++) if (w[j*4 +: 4] != 4'd0) h = j;
        lz_model = 4'b0000;
        for (int i = 0; i < N; i++) if (en && i > h) lz_model[i] = 1'b1;
    endfunction

    // Reference model advanced on each rising edge
    always @(posedge clk) begin
        if (rst) begin
            phase   = 0;
            m_act   = 16'h0000;
            m_pend  = 1'b0;
            m_mask  = 4'b0000;
            m_seg   = 7'h7F;
            m_an    = 4'hF;
            started = 1'b1;
        end else begin
            m_slot = phase / DC;
            m_off  = phase % DC;
            m_an   = 4'hF;
            m_seg  = 7'h7F;
            if (m_off >= GC) begin
                m_an[m_slot] = 1'b0;
                m_seg = m_mask[m_slot] ? 7'h7F : dec_tab[m_act[m_slot*4 +: 4]];
            end
            if (phase == FRAME - 1) begin
                m_w    = m_pend ? m_pend_word : (load_valid ? load_bcd : m_act);
                m_act  = m_w;
                m_mask = lz_model(m_w, blank_lz);
                m_pend = 1'b0;
            end else if (load_valid && !m_pend) begin
                m_pend_word = load_bcd;
                m_pend      = 1'b1;
            end
            phase = (phase + 1) % FRAME;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (started) begin
            check("seg_n", {25'd0, seg_n}, {25'd0, m_seg});
            check("an_n", {28'd0, an_n}, {28'd0, m_an});
            check("load_ready", {31'd0, load_ready}, {31'd0, !m_pend});
            check("frame_done", {31'd0, frame_done}, {31'd0, phase == FRAME - 1});
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [15:0] w);
        int n;
        n = 0;
        load_valid = 1'b1;
        load_bcd   = w;
        while (!load_ready && n < 2 * FRAME) begin
            tick();
            n++;
        end
        check("send_ready", {31'd0, load_ready}, 32'd1);
        tick();
        load_valid = 1'b0;
        load_bcd   = 16'($urandom());
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        @(negedge clk);
        while (frame_done !== 1'b1 && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
        end
        check("wait_frame", {31'd0, frame_done}, 32'd1);
    endtask

    task automatic expect_digit(input logic [3:0] an, input logic [6:0] seg, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (an_n !== an && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
        end
        check({name, "_an"}, {28'd0, an_n}, {28'd0, an});
        check(name, {25'd0, seg_n}, {25'd0, seg});
    endtask

    initial begin
        rst        = 1'b1;
        load_valid = 1'b0;
        load_bcd   = 16'h0000;
        blank_lz   = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_seg", {25'd0, seg_n}, 32'h7F);
        check("rst_an", {28'd0, an_n}, 32'hF);
        check("rst_ready", {31'd0, load_ready}, 32'd1);
        check("rst_fdone", {31'd0, frame_done}, 32'd0);

        // Scan order
        send(16'h1234);
        wait_frame();
        expect_digit(4'b1110, 7'b0011001, "scan_d0");
        expect_digit(4'b1101, 7'b0110000, "scan_d1");
        expect_digit(4'b1011, 7'b0100100, "scan_d2");
        expect_digit(4'b0111, 7'b1111001, "scan_d3");

        // Tear-free commit with a stalled second word
        repeat (5) tick();
        send(16'h1111);
        load_valid = 1'b1;
        load_bcd   = 16'h2222;
        check("stall_ready", {31'd0, load_ready}, 32'd0);
        send(16'h2222);
        expect_digit(4'b1110, 7'b1111001, "tear_first");
        expect_digit(4'b0111, 7'b1111001, "tear_first_d3");
        wait_frame();
        expect_digit(4'b1110, 7'b0100100, "tear_second");

        // Bypass on the commit cycle
        wait_frame();
        load_valid = 1'b1;
        load_bcd   = 16'h0007;
        check("bypass_ready", {31'd0, load_ready}, 32'd1);
        tick();
        load_valid = 1'b0;
        check("bypass_ready_after", {31'd0, load_ready}, 32'd1);
        expect_digit(4'b1110, 7'b1111000, "bypass_d0");
        expect_digit(4'b1101, 7'b1000000, "bypass_d1");

        // Leading-zero blanking
        blank_lz = 1'b1;
        send(16'h0090);
        wait_frame();
        expect_digit(4'b1110, 7'b1000000, "lz90_d0");
        expect_digit(4'b1101, 7'b0010000, "lz90_d1");
        expect_digit(4'b1011, 7'h7F, "lz90_d2");
        expect_digit(4'b0111, 7'h7F, "lz90_d3");
        send(16'h0000);
        wait_frame();
        expect_digit(4'b1110, 7'b1000000, "lz0_d0");
        expect_digit(4'b1101, 7'h7F, "lz0_d1");
        expect_digit(4'b1011, 7'h7F, "lz0_d2");
        expect_digit(4'b0111, 7'h7F, "lz0_d3");

        // Invalid nibble
        blank_lz = 1'b0;
        send(16'h00A5);
        wait_frame();
        expect_digit(4'b1110, 7'b0010010, "inv_d0");
        expect_digit(4'b1101, 7'h7F, "inv_d1");
        expect_digit(4'b1011, 7'b1000000, "inv_d2");
        expect_digit(4'b0111, 7'b1000000, "inv_d3");

        // Reset mid-SHOW with a word pending
        wait_frame();
        expect_digit(4'b1101, 7'h7F, "pre_reset");
        send(16'h0009);
        rst = 1'b1;
        tick();
        check("mid_rst_seg", {25'd0, seg_n}, 32'h7F);
        check("mid_rst_an", {28'd0, an_n}, 32'hF);
        check("mid_rst_ready", {31'd0, load_ready}, 32'd1);
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("post_rst_guard", {28'd0, an_n}, 32'hF);
        @(negedge clk);
        check("post_rst_show_an", {28'd0, an_n}, 32'hE);
        check("post_rst_show_seg", {25'd0, seg_n}, 32'h40);
        wait_frame();
        expect_digit(4'b1110, 7'b1000000, "pending_discarded");

        repeat (4) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
